// File: rtl/sd_emmc_burst_dma.sv
// SDMA burst engine for the SD/eMMC host controller.
// Moves whole blocks between the data FIFO pair and system memory with
// fixed-length AXI4 INCR bursts. It keeps one burst outstanding at a time,
// pauses at SDMA buffer boundaries until software reloads the address, and
// stops cleanly on abort or on an AXI error response.
module sd_emmc_burst_dma #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16,
   parameter int BLKCNT_W  = 16,
   parameter int BLKSZ_W   = 12
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                dir,
   input  logic [ADDR_W-1:0]   sys_addr,
   input  logic                sys_addr_wr,
   input  logic [2:0]          buf_boundary,
   input  logic [BLKSZ_W-1:0]  blk_size,
   input  logic [BLKCNT_W-1:0] blk_count,
   input  logic                blk_count_ena,
   input  logic                abort,
   input  logic                xfer_compl,
   output logic                blk_ready,
   output logic [2:0]          dma_int,
   input  logic [2:0]          int_clr,
   output logic                busy,
   input  logic [BLKSZ_W-1:0]  rx_count,
   output logic                rx_rd_en,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic [BLKSZ_W-1:0]  tx_free,
   output logic                tx_wr_en,
   output logic [DATA_W-1:0]   tx_data,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic [7:0]          m_awlen,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic                m_wlast,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic [7:0]          m_arlen,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rlast,
   input  logic                m_rvalid,
   output logic                m_rready
);

   localparam int BEAT_B   = DATA_W / 8;
   localparam int BURST_B  = BURST_LEN * BEAT_B;
   localparam int BURST_SH = $clog2(BURST_B);

   localparam logic [7:0]          AXLEN        = 8'(BURST_LEN - 1);
   localparam logic [7:0]          LAST_BEAT    = 8'(BURST_LEN - 1);
   localparam logic [7:0]          PRELAST_BEAT = 8'(BURST_LEN - 2);
   localparam logic [BLKSZ_W-1:0]  BURST_WORDS  = BLKSZ_W'(BURST_LEN);
   localparam logic [BLKSZ_W-1:0]  ONE_B        = BLKSZ_W'(1);
   localparam logic [BLKCNT_W-1:0] ONE_C        = BLKCNT_W'(1);
   localparam logic [ADDR_W-1:0]   BURST_INC    = ADDR_W'(BURST_B);
   localparam logic [ADDR_W-1:0]   ONE_A        = ADDR_W'(1);

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_WR_WAIT    = 4'd1,
      ST_WR_ADDR    = 4'd2,
      ST_WR_DATA    = 4'd3,
      ST_WR_RESP    = 4'd4,
      ST_RD_WAIT    = 4'd5,
      ST_RD_ADDR    = 4'd6,
      ST_RD_DATA    = 4'd7,
      ST_BLK_DONE   = 4'd8,
      ST_BOUND_WAIT = 4'd9,
      ST_FINISH     = 4'd10
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [BLKSZ_W-1:0]  blk_size_r;
   logic [BLKCNT_W-1:0] blk_count_r;
   logic                dir_r;
   logic [BLKCNT_W-1:0] blocks_done_r;
   logic [BLKSZ_W-1:0]  burst_cnt_r;
   logic [7:0]          beat_cnt_r;
   logic                abort_pend_r;
   logic                rd_err_r;

   logic [BLKSZ_W-1:0]  bursts_per_blk_s;
   logic                last_burst_s;
   logic [BLKCNT_W-1:0] blocks_next_s;
   logic                finish_s;
   logic [ADDR_W-1:0]   bound_mask_s;
   logic                at_bound_s;
   logic                abort_now_s;
   logic                rd_err_s;
   logic                wr_end_s;
   logic                rd_end_s;
   logic                burst_err_s;
   logic [2:0]          int_set_s;
   state_t              post_burst_state_s;
   state_t              next_blk_state_s;

   // Burst/block bookkeeping decoded from the latched transfer setup.
   assign bursts_per_blk_s = blk_size_r >> BURST_SH;
   assign last_burst_s     = (burst_cnt_r == (bursts_per_blk_s - ONE_B));
   assign blocks_next_s    = blocks_done_r + ONE_C;
   assign finish_s         = blk_count_ena && (blocks_next_s == blk_count_r);
   assign bound_mask_s     = (ONE_A << (5'd12 + {2'b00, buf_boundary})) - ONE_A;
   assign at_bound_s       = ((addr_r & bound_mask_s) == {ADDR_W{1'b0}});
   assign abort_now_s      = abort_pend_r | abort;
   assign rd_err_s         = rd_err_r | (m_rresp != 2'b00);
   assign wr_end_s         = (state_r == ST_WR_RESP) && m_bvalid;
   assign rd_end_s         = (state_r == ST_RD_DATA) && m_rvalid && m_rlast;
   assign next_blk_state_s = dir_r ? ST_WR_WAIT : ST_RD_WAIT;

   // The write data path is the show-ahead FIFO head; pop exactly on a W handshake.
   assign m_wdata  = m_wvalid ? rx_data : {DATA_W{1'b0}};
   assign rx_rd_en = m_wvalid & m_wready;
   assign busy     = (state_r != ST_IDLE);

   // Error status of the burst that is ending this cycle.
   always_comb begin
      burst_err_s = 1'b0;
      if (wr_end_s) begin
         burst_err_s = (m_bresp != 2'b00);
      end else if (rd_end_s) begin
         burst_err_s = rd_err_s;
      end else begin
         burst_err_s = 1'b0;
      end
   end

   // Where to go once a burst has fully completed.
   always_comb begin
      post_burst_state_s = ST_IDLE;
      if (burst_err_s || abort_now_s) begin
         post_burst_state_s = ST_IDLE;
      end else if (last_burst_s) begin
         post_burst_state_s = ST_BLK_DONE;
      end else begin
         post_burst_state_s = next_blk_state_s;
      end
   end

   // Interrupt set events: complete, boundary pause, AXI error.
   always_comb begin
      int_set_s    = 3'b000;
      int_set_s[0] = (state_r == ST_FINISH) && xfer_compl;
      int_set_s[1] = (state_r == ST_BLK_DONE) && !finish_s && at_bound_s;
      int_set_s[2] = (wr_end_s || rd_end_s) && burst_err_s;
   end

   // Sticky interrupt status; a set in the same cycle as a clear wins.
   always_ff @(posedge clock) begin
      if (!reset) begin
         dma_int <= 3'b000;
      end else begin
         dma_int <= (dma_int & ~int_clr) | int_set_s;
      end
   end

   // Main transfer FSM with registered AXI and FIFO controls.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         addr_r        <= {ADDR_W{1'b0}};
         blk_size_r    <= {BLKSZ_W{1'b0}};
         blk_count_r   <= {BLKCNT_W{1'b0}};
         dir_r         <= 1'b0;
         blocks_done_r <= {BLKCNT_W{1'b0}};
         burst_cnt_r   <= {BLKSZ_W{1'b0}};
         beat_cnt_r    <= 8'd0;
         abort_pend_r  <= 1'b0;
         rd_err_r      <= 1'b0;
         blk_ready     <= 1'b0;
         tx_wr_en      <= 1'b0;
         tx_data       <= {DATA_W{1'b0}};
         m_awaddr      <= {ADDR_W{1'b0}};
         m_awlen       <= 8'd0;
         m_awvalid     <= 1'b0;
         m_wlast       <= 1'b0;
         m_wvalid      <= 1'b0;
         m_bready      <= 1'b0;
         m_araddr      <= {ADDR_W{1'b0}};
         m_arlen       <= 8'd0;
         m_arvalid     <= 1'b0;
         m_rready      <= 1'b0;
      end else begin
         tx_wr_en  <= 1'b0;
         blk_ready <= 1'b0;
         // An abort is remembered until the engine can stop at a burst edge.
         abort_pend_r <= (state_r != ST_IDLE) ? (abort_pend_r | abort) : 1'b0;

         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  addr_r        <= sys_addr;
                  blk_size_r    <= blk_size;
                  blk_count_r   <= blk_count;
                  dir_r         <= dir;
                  blocks_done_r <= {BLKCNT_W{1'b0}};
                  burst_cnt_r   <= {BLKSZ_W{1'b0}};
                  state_r       <= dir ? ST_WR_WAIT : ST_RD_WAIT;
               end
            end

            ST_WR_WAIT: begin
               if (abort_now_s) begin
                  state_r <= ST_IDLE;
               end else if (rx_count >= BURST_WORDS) begin
                  m_awaddr  <= addr_r;
                  m_awlen   <= AXLEN;
                  m_awvalid <= 1'b1;
                  state_r   <= ST_WR_ADDR;
               end
            end

            ST_WR_ADDR: begin
               if (m_awready) begin
                  m_awvalid  <= 1'b0;
                  m_wvalid   <= 1'b1;
                  m_wlast    <= (LAST_BEAT == 8'd0);
                  beat_cnt_r <= 8'd0;
                  state_r    <= ST_WR_DATA;
               end
            end

            ST_WR_DATA: begin
               if (m_wready) begin
                  beat_cnt_r <= beat_cnt_r + 8'd1;
                  if (beat_cnt_r == LAST_BEAT) begin
                     m_wvalid <= 1'b0;
                     m_wlast  <= 1'b0;
                     m_bready <= 1'b1;
                     state_r  <= ST_WR_RESP;
                  end else if (beat_cnt_r == PRELAST_BEAT) begin
                     m_wlast <= 1'b1;
                  end
               end
            end

            ST_WR_RESP: begin
               if (m_bvalid) begin
                  m_bready    <= 1'b0;
                  addr_r      <= addr_r + BURST_INC;
                  burst_cnt_r <= last_burst_s ? {BLKSZ_W{1'b0}} : (burst_cnt_r + ONE_B);
                  state_r     <= post_burst_state_s;
               end
            end

            ST_RD_WAIT: begin
               if (abort_now_s) begin
                  state_r <= ST_IDLE;
               end else if (tx_free >= BURST_WORDS) begin
                  m_araddr  <= addr_r;
                  m_arlen   <= AXLEN;
                  m_arvalid <= 1'b1;
                  state_r   <= ST_RD_ADDR;
               end
            end

            ST_RD_ADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  rd_err_r  <= 1'b0;
                  state_r   <= ST_RD_DATA;
               end
            end

            ST_RD_DATA: begin
               if (m_rvalid) begin
                  // Once a beat has errored, the rest of the burst is drained and dropped.
                  tx_wr_en <= ~rd_err_s;
                  tx_data  <= m_rdata;
                  rd_err_r <= rd_err_s;
                  if (m_rlast) begin
                     m_rready    <= 1'b0;
                     addr_r      <= addr_r + BURST_INC;
                     burst_cnt_r <= last_burst_s ? {BLKSZ_W{1'b0}} : (burst_cnt_r + ONE_B);
                     state_r     <= post_burst_state_s;
                  end
               end
            end

            ST_BLK_DONE: begin
               blocks_done_r <= blocks_next_s;
               blk_ready     <= ~dir_r;
               if (finish_s) begin
                  state_r <= ST_FINISH;
               end else if (at_bound_s) begin
                  state_r <= ST_BOUND_WAIT;
               end else begin
                  state_r <= next_blk_state_s;
               end
            end

            ST_BOUND_WAIT: begin
               if (abort_now_s) begin
                  state_r <= ST_IDLE;
               end else if (sys_addr_wr) begin
                  addr_r  <= sys_addr;
                  state_r <= next_blk_state_s;
               end
            end

            ST_FINISH: begin
               if (xfer_compl) begin
                  state_r <= ST_IDLE;
               end
            end

            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_emmc_burst_dma.sv
// Directed bench for sd_emmc_burst_dma: AXI slave/FIFO models plus a linear
// sequence of transfer scenarios with hand-computed expected results.
module tb_sd_emmc_burst_dma;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int BURST_LEN = 16;
   localparam int BLKCNT_W  = 16;
   localparam int BLKSZ_W   = 12;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                reset;
   logic                start;
   logic                dir;
   logic [ADDR_W-1:0]   sys_addr;
   logic                sys_addr_wr;
   logic [2:0]          buf_boundary;
   logic [BLKSZ_W-1:0]  blk_size;
   logic [BLKCNT_W-1:0] blk_count;
   logic                blk_count_ena;
   logic                abort;
   logic                xfer_compl;
   logic                blk_ready;
   logic [2:0]          dma_int;
   logic [2:0]          int_clr;
   logic                busy;
   logic [BLKSZ_W-1:0]  rx_count;
   logic                rx_rd_en;
   logic [DATA_W-1:0]   rx_data;
   logic [BLKSZ_W-1:0]  tx_free;
   logic                tx_wr_en;
   logic [DATA_W-1:0]   tx_data;
   logic [ADDR_W-1:0]   m_awaddr;
   logic [7:0]          m_awlen;
   logic                m_awvalid;
   logic                m_awready;
   logic [DATA_W-1:0]   m_wdata;
   logic                m_wlast;
   logic                m_wvalid;
   logic                m_wready;
   logic [1:0]          m_bresp;
   logic                m_bvalid;
   logic                m_bready;
   logic [ADDR_W-1:0]   m_araddr;
   logic [7:0]          m_arlen;
   logic                m_arvalid;
   logic                m_arready;
   logic [DATA_W-1:0]   m_rdata;
   logic [1:0]          m_rresp;
   logic                m_rlast;
   logic                m_rvalid;
   logic                m_rready;

   sd_emmc_burst_dma #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
      .BLKCNT_W(BLKCNT_W), .BLKSZ_W(BLKSZ_W)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .dir(dir),
      .sys_addr(sys_addr), .sys_addr_wr(sys_addr_wr), .buf_boundary(buf_boundary),
      .blk_size(blk_size), .blk_count(blk_count), .blk_count_ena(blk_count_ena),
      .abort(abort), .xfer_compl(xfer_compl), .blk_ready(blk_ready),
      .dma_int(dma_int), .int_clr(int_clr), .busy(busy),
      .rx_count(rx_count), .rx_rd_en(rx_rd_en), .rx_data(rx_data),
      .tx_free(tx_free), .tx_wr_en(tx_wr_en), .tx_data(tx_data),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
      .m_rready(m_rready)
   );

   int checks   = 0;
   int failures = 0;

   // Monitor / model state (written only by the monitor process).
   logic        clr = 1'b0;
   int          err_idx;
   logic [1:0]  cyc = 2'd0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, brdy_cnt = 0;
   int          wlast_bad = 0, wdata_bad = 0, proto_bad = 0;
   int          wbeat = 0, rbeat = 0;
   logic [31:0] rx_word = 32'd0, rd_word = 32'd0;
   logic        awv_pend = 1'b0, wv_pend = 1'b0, arv_pend = 1'b0;
   logic [31:0] aw_q[$];
   logic [31:0] ar_q[$];
   logic [31:0] tx_q[$];

   assign m_awready = cyc[0];
   assign m_wready  = (cyc != 2'd3);
   assign m_arready = cyc[1];
   assign rx_data   = rx_word;
   assign m_rresp   = 2'b00;

   // Handshake monitor, RX FIFO model and protocol watch.
   always @(posedge clock) begin
      cyc <= cyc + 2'd1;
      if (clr) begin
         aw_q.delete(); ar_q.delete(); tx_q.delete();
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; brdy_cnt <= 0;
         wlast_bad <= 0; wdata_bad <= 0; proto_bad <= 0; wbeat <= 0;
         rx_word <= 32'd0;
      end else begin
         if (m_awvalid && m_awready) begin
            aw_q.push_back(m_awaddr);
            aw_cnt <= aw_cnt + 1;
            if (m_awlen !== 8'd15) proto_bad <= proto_bad + 1;
         end
         if (m_arvalid && m_arready) begin
            ar_q.push_back(m_araddr);
            ar_cnt <= ar_cnt + 1;
            if (m_arlen !== 8'd15) proto_bad <= proto_bad + 1;
         end
         if (m_wvalid && m_wready) begin
            w_cnt <= w_cnt + 1;
            if (m_wlast !== (wbeat == 15)) wlast_bad <= wlast_bad + 1;
            if (m_wdata !== 32'(w_cnt)) wdata_bad <= wdata_bad + 1;
            wbeat <= (wbeat == 15) ? 0 : wbeat + 1;
         end
         if (rx_rd_en) rx_word <= rx_word + 32'd1;
         if (m_bvalid && m_bready) b_cnt <= b_cnt + 1;
         if (blk_ready) brdy_cnt <= brdy_cnt + 1;
         if (tx_wr_en) tx_q.push_back(tx_data);
         if (reset && ((awv_pend && !m_awvalid) || (wv_pend && !m_wvalid) || (arv_pend && !m_arvalid)))
            proto_bad <= proto_bad + 1;
      end
      awv_pend <= reset && m_awvalid && !m_awready;
      wv_pend  <= reset && m_wvalid && !m_wready;
      arv_pend <= reset && m_arvalid && !m_arready;
   end

   // AXI B channel responder; burst number err_idx gets SLVERR.
   always @(posedge clock) begin
      if (!reset) begin
         m_bvalid <= 1'b0;
         m_bresp  <= 2'b00;
      end else if (m_bvalid && m_bready) begin
         m_bvalid <= 1'b0;
      end else if (m_wvalid && m_wready && m_wlast) begin
         m_bvalid <= 1'b1;
         m_bresp  <= (b_cnt == err_idx) ? 2'b10 : 2'b00;
      end
   end

   // AXI R channel responder: 16 beats of an incrementing word stream.
   always @(posedge clock) begin
      if (!reset) begin
         m_rvalid <= 1'b0; m_rlast <= 1'b0; m_rdata <= 32'd0; rbeat <= 0;
      end else if (clr) begin
         rd_word <= 32'd0;
      end else if (m_arvalid && m_arready) begin
         m_rvalid <= 1'b1; m_rdata <= rd_word; m_rlast <= 1'b0; rbeat <= 0;
      end else if (m_rvalid && m_rready) begin
         rd_word <= rd_word + 32'd1;
         if (m_rlast) begin
            m_rvalid <= 1'b0; m_rlast <= 1'b0;
         end else begin
            m_rdata <= rd_word + 32'd1; rbeat <= rbeat + 1; m_rlast <= (rbeat == 14);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic clear_mon();
      clr = 1'b1; @(negedge clock); clr = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; @(negedge clock); start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int n = 0; n < 4000 && busy; n++) @(negedge clock);
      check(tag, 32'(busy), 32'd0);
   endtask

   int mism;
   logic [31:0] last_a;

   initial begin
      reset = 1'b0; start = 1'b0; dir = 1'b0; sys_addr = 32'd0; sys_addr_wr = 1'b0;
      buf_boundary = 3'd0; blk_size = 12'd0; blk_count = 16'd0; blk_count_ena = 1'b1;
      abort = 1'b0; xfer_compl = 1'b0; int_clr = 3'b000;
      rx_count = 12'd100; tx_free = 12'd64; err_idx = -1;
      cycles(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dma_int", 32'(dma_int), 32'd0);
      check("rst_awvalid", 32'(m_awvalid), 32'd0);
      check("rst_arvalid", 32'(m_arvalid), 32'd0);
      check("rst_wvalid", 32'(m_wvalid), 32'd0);
      check("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
      check("rst_blk_ready", 32'(blk_ready), 32'd0);
      check("rst_rx_rd_en", 32'(rx_rd_en), 32'd0);
      reset = 1'b1;
      cycles(1);

      // Card->memory, two 512-byte blocks from 0x1000.
      clear_mon();
      dir = 1'b1; blk_size = 12'd512; blk_count = 16'd2; sys_addr = 32'h1000; buf_boundary = 3'd0;
      pulse_start();
      for (int n = 0; n < 2000 && aw_cnt < 2; n++) @(negedge clock);
      sys_addr = 32'h9000; dir = 1'b0;   // start while busy must be ignored
      pulse_start();
      dir = 1'b1;
      for (int n = 0; n < 4000 && b_cnt < 16; n++) @(negedge clock);
      check("wr_b_cnt", 32'(b_cnt), 32'd16);
      cycles(5);
      check("wr_busy_finish", 32'(busy), 32'd1);
      check("wr_int_pre", 32'(dma_int), 32'd0);
      xfer_compl = 1'b1; @(negedge clock); xfer_compl = 1'b0;
      check("wr_int_done", 32'(dma_int), 32'd1);
      check("wr_busy_done", 32'(busy), 32'd0);
      check("wr_aw_cnt", 32'(aw_cnt), 32'd16);
      mism = 0;
      foreach (aw_q[i]) if (aw_q[i] !== 32'h1000 + 32'(i) * 32'd64) mism++;
      check("wr_aw_addr", 32'(mism), 32'd0);
      check("wr_w_cnt", 32'(w_cnt), 32'd256);
      check("wr_wlast", 32'(wlast_bad), 32'd0);
      check("wr_wdata", 32'(wdata_bad), 32'd0);
      check("wr_proto", 32'(proto_bad), 32'd0);
      int_clr = 3'b111; @(negedge clock); int_clr = 3'b000;
      check("clr_all", 32'(dma_int), 32'd0);

      // Memory->card with TX space starving the first burst.
      clear_mon();
      dir = 1'b0; tx_free = 12'd8; sys_addr = 32'h1000;
      pulse_start();
      cycles(30);
      check("rd_no_ar_low_space", 32'(ar_cnt), 32'd0);
      check("rd_busy_wait", 32'(busy), 32'd1);
      tx_free = 12'd64;
      for (int n = 0; n < 4000 && tx_q.size() < 256; n++) @(negedge clock);
      cycles(5);
      check("rd_tx_words", 32'(tx_q.size()), 32'd256);
      mism = 0;
      foreach (tx_q[i]) if (tx_q[i] !== 32'(i)) mism++;
      check("rd_tx_order", 32'(mism), 32'd0);
      check("rd_ar_cnt", 32'(ar_cnt), 32'd16);
      mism = 0;
      foreach (ar_q[i]) if (ar_q[i] !== 32'h1000 + 32'(i) * 32'd64) mism++;
      check("rd_ar_addr", 32'(mism), 32'd0);
      check("rd_blk_ready", 32'(brdy_cnt), 32'd2);
      check("rd_proto", 32'(proto_bad), 32'd0);
      xfer_compl = 1'b1; @(negedge clock); xfer_compl = 1'b0;
      check("rd_int_done", 32'(dma_int), 32'd1);
      int_clr = 3'b111; @(negedge clock); int_clr = 3'b000;

      // 4 KiB boundary: 64-byte blocks from 0x0E00 reach 0x1000 after block 8.
      clear_mon();
      dir = 1'b1; buf_boundary = 3'd0; blk_size = 12'd64; blk_count = 16'd16; sys_addr = 32'h0E00;
      pulse_start();
      for (int n = 0; n < 4000 && !dma_int[1]; n++) @(negedge clock);
      check("bnd_int", 32'(dma_int), 32'd2);
      check("bnd_aw_cnt", 32'(aw_cnt), 32'd8);
      last_a = (aw_q.size() >= 8) ? aw_q[7] : 32'hDEAD_BEEF;
      check("bnd_last_addr", last_a, 32'h0FC0);
      cycles(30);
      check("bnd_quiet", 32'(aw_cnt), 32'd8);
      check("bnd_busy", 32'(busy), 32'd1);
      sys_addr = 32'h8000; sys_addr_wr = 1'b1; @(negedge clock); sys_addr_wr = 1'b0;
      for (int n = 0; n < 200 && aw_cnt < 9; n++) @(negedge clock);
      last_a = (aw_q.size() >= 9) ? aw_q[8] : 32'hDEAD_BEEF;
      check("bnd_resume_addr", last_a, 32'h8000);
      abort = 1'b1; @(negedge clock); abort = 1'b0;
      wait_idle("bnd_abort_idle");
      check("bnd_abort_aw", 32'(aw_cnt), 32'd9);
      check("bnd_abort_w", 32'(w_cnt), 32'd144);
      check("bnd_abort_int", 32'(dma_int), 32'd2);
      int_clr = 3'b111; @(negedge clock); int_clr = 3'b000;

      // SLVERR on the second write burst.
      clear_mon();
      err_idx = 1; blk_size = 12'd512; blk_count = 16'd2; sys_addr = 32'h2000;
      pulse_start();
      wait_idle("err_idle");
      check("err_int", 32'(dma_int), 32'd4);
      check("err_aw_cnt", 32'(aw_cnt), 32'd2);
      check("err_w_cnt", 32'(w_cnt), 32'd32);
      cycles(20);
      check("err_no_more_aw", 32'(aw_cnt), 32'd2);
      err_idx = -1;
      int_clr = 3'b111; @(negedge clock); int_clr = 3'b000;

      // Abort during beat 5 of the first write burst.
      clear_mon();
      sys_addr = 32'h3000;
      pulse_start();
      for (int n = 0; n < 200 && w_cnt < 5; n++) @(negedge clock);
      abort = 1'b1; @(negedge clock); abort = 1'b0;
      wait_idle("abt_idle");
      check("abt_w_cnt", 32'(w_cnt), 32'd16);
      check("abt_b_cnt", 32'(b_cnt), 32'd1);
      check("abt_aw_cnt", 32'(aw_cnt), 32'd1);
      check("abt_int", 32'(dma_int), 32'd0);
      check("abt_wlast", 32'(wlast_bad), 32'd0);

      // Completion set coinciding with a clear of the same bit.
      clear_mon();
      blk_size = 12'd64; blk_count = 16'd1; sys_addr = 32'h4000;
      pulse_start();
      for (int n = 0; n < 200 && b_cnt < 1; n++) @(negedge clock);
      cycles(4);
      check("race_in_finish", 32'(busy), 32'd1);
      xfer_compl = 1'b1; int_clr = 3'b001; @(negedge clock);
      xfer_compl = 1'b0; int_clr = 3'b000;
      check("race_set_wins", 32'(dma_int), 32'd1);
      int_clr = 3'b001; @(negedge clock); int_clr = 3'b000;
      check("race_later_clr", 32'(dma_int), 32'd0);

      // Reset in the middle of a write burst.
      clear_mon();
      blk_size = 12'd512; blk_count = 16'd2; sys_addr = 32'h5000;
      pulse_start();
      for (int n = 0; n < 200 && w_cnt < 3; n++) @(negedge clock);
      reset = 1'b0; @(negedge clock);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_wvalid", 32'(m_wvalid), 32'd0);
      reset = 1'b1;
      cycles(5);
      check("mid_rst_stay_idle", 32'(busy), 32'd0);
      check("mid_rst_int", 32'(dma_int), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
